// File: rtl/led7_pkg.sv
// led7_pkg: shared segment font, blank pattern and DP bit position for the 7-segment scanner
package led7_pkg;
  typedef logic [7:0] seg_t;
  localparam seg_t SEG_BLANK = 8'h00;
  localparam int DP_BIT = 7;
  localparam seg_t SEG_FONT [16] = '{
    8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h72,
    8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h0D, 8'h3D, 8'h4F, 8'h47
  };
endpackage

// File: rtl/led7_font.sv
// led7_font: combinational hex nibble to a..g segment lookup
module led7_font
  import led7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = SEG_FONT[nib];
endmodule

// File: rtl/led7_scan.sv
// led7_scan: time-multiplexed 7-segment driver with dwell, guard, frame-synchronous load and zero suppression
module led7_scan
  import led7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  en,
  input  logic                  lzs,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [DW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_val, shad_val;
  logic [DIGITS-1:0]     pend_dp, shad_dp, sup;
  logic                  pend_valid, div_wrap, bnd, lit, run;
  seg_t                  font_seg, seg_nxt;
  assign div_wrap = div_cnt == DW'(SCAN_DIV - 1);
  assign bnd      = div_wrap && idx == IW'(DIGITS - 1);
  assign lit      = en && int'(div_cnt) >= GUARD;
  led7_font u_font (
    .nib (shad_val[4*idx +: 4]),
    .seg (font_seg)
  );
  // a digit is blanked when it and every more significant nibble are zero; digit 0 always shows
  always_comb begin
    run = lzs;
    sup = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run    = run && shad_val[4*i +: 4] == 4'h0;
      sup[i] = run;
    end
  end
  // segment pattern for the current slot; DP survives suppression
  always_comb begin
    seg_nxt         = sup[idx] ? SEG_BLANK : font_seg;
    seg_nxt[DP_BIT] = shad_dp[idx];
  end
  // slot divider, digit index and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
      idx        <= div_wrap ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
      frame_done <= bnd;
    end
  end
  // pending capture and tear-free shadow update at the frame boundary, live load bypasses pending
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      shad_val   <= '0;
      shad_dp    <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp;
      end
      pend_valid <= bnd ? 1'b0 : load | pend_valid;
      if (bnd && (load || pend_valid)) begin
        shad_val <= load ? value : pend_val;
        shad_dp  <= load ? dp : pend_dp;
      end
    end
  end
  // registered pin drive, dark during guard cycles or when disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_BLANK;
      dig_sel <= '0;
    end else begin
      seg_out <= lit ? seg_nxt : SEG_BLANK;
      dig_sel <= lit ? DIGITS'(1) << idx : '0;
    end
  end
endmodule

// File: tb/tb_led7_scan.sv
// tb_led7_scan: scoreboard bench, stimulus queues expected slot contents, monitor checks each lit slot
module tb_led7_scan;
  logic        clk = 1'b0;
  logic        rst, load, en, lzs;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;
  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
  } exp_t;
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_fd = 0;
  bit   have_fd = 0;
  logic [3:0] prev_dig;
  led7_scan #(.DIGITS(4), .SCAN_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .en         (en),
    .lzs        (lzs),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [3:0] d, input logic [7:0] s);
    exp_t e;
    e.dig = d;
    e.seg = s;
    q.push_back(e);
  endtask
  task automatic push_frame(input logic [7:0] s0, s1, s2, s3);
    push(4'b0001, s0);
    push(4'b0010, s1);
    push(4'b0100, s2);
    push(4'b1000, s3);
  endtask
  task automatic wait_fd();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) return;
    end
    chk("fd_timeout", 0, 1);
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask
  // monitor: every time a digit lights up, compare against the next queued expectation
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst === 1'b1) begin
      have_fd = 0;
    end else begin
      if (frame_done === 1'b1) begin
        if (have_fd) chk("fd_period", cyc - last_fd, 32);
        have_fd = 1;
        last_fd = cyc;
      end
      if (dig_sel !== 4'b0000 && prev_dig === 4'b0000) begin
        if (q.size() == 0) chk("unexpected_slot", {4'h0, dig_sel}, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("slot_dig", {28'h0, dig_sel}, {28'h0, e.dig});
          chk("slot_seg", {24'h0, seg_out}, {24'h0, e.seg});
        end
      end
    end
    prev_dig = dig_sel;
  end
  initial begin
    rst = 1'b1; load = 1'b1; en = 1'b1; lzs = 1'b0; value = 16'hFFFF; dp = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_seg", {24'h0, seg_out}, 0);
      chk("rst_dig", {28'h0, dig_sel}, 0);
      chk("rst_fd", {31'h0, frame_done}, 0);
    end
    rst = 1'b0; load = 1'b0; value = 16'h0; dp = 4'h0;
    push_frame(8'h7E, 8'h7E, 8'h7E, 8'h7E);
    @(negedge clk);
    @(negedge clk);
    chk("first_guard_dig", {28'h0, dig_sel}, 0);
    @(negedge clk);
    chk("first_lit_dig", {28'h0, dig_sel}, 1);
    chk("first_lit_seg", {24'h0, seg_out}, 8'h7E);
    do_load(16'h12AF, 4'b0100);
    wait_fd();
    push_frame(8'h47, 8'h77, 8'hED, 8'h30);
    do_load(16'h0030, 4'b0000);
    wait_fd();
    lzs = 1'b1;
    push_frame(8'h7E, 8'h79, 8'h00, 8'h00);
    do_load(16'h0000, 4'b1000);
    wait_fd();
    push_frame(8'h7E, 8'h00, 8'h00, 8'h80);
    wait_fd();
    lzs = 1'b0;
    push(4'b0001, 8'h7E);
    push(4'b0010, 8'h7E);
    repeat (13) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_seg", {24'h0, seg_out}, 0);
    chk("en_off_dig", {28'h0, dig_sel}, 0);
    en = 1'b1;
    push(4'b0010, 8'h7E);
    push(4'b0100, 8'h7E);
    push(4'b1000, 8'hFE);
    @(negedge clk);
    value = 16'h1111; dp = 4'h0; load = 1'b1;
    @(negedge clk);
    value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    push_frame(8'h6D, 8'h6D, 8'h6D, 8'h6D);
    do_load(16'h9999, 4'hF);
    repeat (29) @(negedge clk);
    value = 16'h3456; dp = 4'b0001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("bnd_fd", {31'h0, frame_done}, 1);
    push(4'b0001, 8'hDF);
    push(4'b0010, 8'h5B);
    push(4'b0100, 8'h33);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_seg", {24'h0, seg_out}, 0);
    chk("midrst_dig", {28'h0, dig_sel}, 0);
    chk("midrst_fd", {31'h0, frame_done}, 0);
    rst = 1'b0;
    push_frame(8'h7E, 8'h7E, 8'h7E, 8'h7E);
    wait_fd();
    push_frame(8'h7E, 8'h7E, 8'h7E, 8'h7E);
    wait_fd();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/led7_scan.md
Name: led7_scan

Overview:
- Time-multiplexed driver for a DIGITS-wide common-segment 7-segment display bank; the parametrised successor of the single-digit hex decoder with blank enable.
- Takes a packed hex value plus per-digit decimal points and scans one digit at a time.
- Adds a programmable dwell, ghosting guard, tear-free frame-synchronous loading and leading-zero suppression.
- Sits between the datapath register file and the board segment/digit pins.

Parameters:
- DIGITS, 4, number of digits scanned (legal 1..8).
- SCAN_DIV, 1000, clock cycles each digit slot lasts (legal >= GUARD+2).
- GUARD, 2, cycles at the start of each slot with all digits off (anti-ghosting; legal >= 0).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- value  in  4*DIGITS  hex digits; nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost/least significant.
- dp  in  DIGITS  decimal point request per digit.
- load  in  1  capture strobe for value/dp.
- en  in  1  display enable; 0 blanks the display, scanning continues.
- lzs  in  1  leading-zero suppression enable.
- seg_out  out  8  bit7=DP, bits6..0 = a..g, active-high.
- dig_sel  out  DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse after the last slot of a frame ends.

Behaviour:
- Reset is synchronous and active-high; one clock. While rst=1 at a clock edge, all registers clear on that edge: seg_out=0, dig_sel=0, frame_done=0, div_cnt=0, idx=0, shadow and pending value/dp=0, pending_valid=0. Reset mid-scan aborts the slot; the next slot starts at idx 0.
- div_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx advances; idx DIGITS-1 wraps to 0. Frame length is DIGITS*SCAN_DIV cycles.
- frame_done is registered: high for exactly the one cycle after the edge where div_cnt=SCAN_DIV-1 and idx=DIGITS-1.
- Load path:
  - load=1 captures value/dp into the pending register and sets pending_valid.
  - At a frame boundary (same condition as frame_done) with pending_valid=1, shadow<=pending and pending_valid clears.
  - If load=1 on the boundary cycle itself, the live value/dp go directly to shadow (bypass) and pending_valid clears.
  - Repeated loads within a frame: last one wins. The display never mixes two loads within one frame.
- Font (shared constant, bits 7..0), hex 0-F: 7E 30 6D 79 33 5B 5F 72 7F 7B 77 1F 0D 3D 4F 47.
- Digit i is suppressed when lzs=1, i != 0, and shadow nibbles DIGITS-1 down to i are all zero. A suppressed digit has segments a..g = 0, but its DP bit still follows shadow dp[i]. Digit 0 is never suppressed.
- Outputs are registered with one-cycle latency; seg_out/dig_sel at edge t+1 reflect idx, div_cnt, shadow, en and lzs sampled at edge t:
  - en=0 or div_cnt<GUARD: seg_out=0, dig_sel=0.
  - Otherwise: dig_sel=1<<idx; seg_out = font(shadow nibble idx) with segments masked if suppressed, OR (shadow dp[idx]<<7).
- en and lzs are not registered at the input; a change takes effect on the next output update.
- GUARD=0 disables the guard interval.

Decomposition:
- Package led7_pkg: SEG_FONT[16] constant array, SEG_BLANK=8'h00, DP_BIT=7, seg_t (8-bit) typedef.
- One natural sub-module: led7_font, a combinational nibble-to-segments lookup using SEG_FONT.
- Divider, index, load/shadow and LZS logic stay in led7_scan.

Test Plan (DIGITS=4, SCAN_DIV=8, GUARD=2):
1. Reset: rst=1 for 3 cycles with load=1, en=1 -> seg_out=00, dig_sel=0000, frame_done=0 throughout. After release, the first lit output (digit 0, shadow=0, lzs=0) is 7E with dig_sel=0001, registered from the edge where div_cnt=2.
2. load value=16'h12AF, dp=4'b0100, en=1, lzs=0 -> from the next frame, the slots show digit0 47, digit1 77, digit2 ED, digit3 30. Each slot is 2 cycles dark then 6 lit; frame_done pulses every 32 cycles.
3. lzs=1, value=16'h0030 -> digit3 00, digit2 00, digit1 79, digit0 7E. With value=0 and dp=4'b1000: digit3 80, digit2 00, digit1 00, digit0 7E.
4. en=0 mid-slot -> seg_out=00 and dig_sel=0000 from the next cycle; frame_done keeps pulsing every 32 cycles. en=1 restores the current slot's digit on the next cycle.
5. Mid-frame loads:
   - load 16'h1111 then 16'h2222 within one frame -> the display holds the old value until the boundary, then shows 2222 (segments 6D on every digit).
   - load on the boundary cycle -> that value shows in the next frame.
6. rst pulsed at div_cnt=5, idx=2 -> next cycle all outputs 0. The scan restarts at idx 0; shadow=0, so digit 0 shows 7E with lzs=0.
